add_pipe_arbiter: RTL

Shares one pipelined 32-bit adder (two register stages: operand capture, result capture) among several requesters. Round-robin arbitration grants at most one request per cycle and drives the adder operands. A tag pipeline matched to the adder latency returns each sum to the requester that issued it. The block sits between client logic and the adder instance.

---
 rtl/add_arb_pkg.sv | 21 ++
 rtl/add_pipe_arbiter_rr_arbiter.sv | 46 ++++
 rtl/add_pipe_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/add_arb_pkg.sv
// Shared constants and types for the pipelined-adder arbiter.
// Optional accept counters are built only when ADD_ARB_PERF_EN is defined.
package add_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int LATENCY = 2;

  typedef logic [$clog2(NUM_REQ)-1:0] tag_t;
  typedef logic [15:0] cnt_t;

  typedef struct packed {
    logic vld;
    tag_t tag;
  } tag_stage_t;

  function automatic cnt_t sat_inc(cnt_t c);
    return (c == '1) ? c : c + 16'd1;
  endfunction

endpackage

// File: rtl/add_pipe_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter; search starts one past the
// last accepted index, pointer advances only on an accept.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [TW-1:0]      grant_idx
);

  logic [TW-1:0] ptr;

  // Walk farthest-to-nearest so the nearest valid index wins.
  always_comb begin
    int sel;
    int j;
    sel       = -1;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    if (en && rst_n) begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        j = int'(ptr) + k;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        if (req[j]) sel = j;
      end
      if (sel >= 0) begin
        grant     = NUM_REQ'(1) << sel;
        grant_idx = TW'(sel);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= TW'(NUM_REQ - 1);
    end else if (|grant) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/add_pipe_arbiter.sv
// Shares one pipelined adder among NUM_REQ requesters with tagged returns.
// Define ADD_ARB_PERF_EN to add per-requester saturating accept counters.
module add_pipe_arbiter #(
  parameter int NUM_REQ = add_arb_pkg::NUM_REQ,
  parameter int WIDTH   = add_arb_pkg::WIDTH,
  parameter int LATENCY = add_arb_pkg::LATENCY
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         pipe_a,
  output logic [WIDTH-1:0]         pipe_b,
  input  logic [WIDTH-1:0]         pipe_c,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_c,
  output logic                     busy
`ifdef ADD_ARB_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]    grant_cnt
`endif
);

  import add_arb_pkg::*;

  localparam int TW = $clog2(NUM_REQ);

  typedef struct packed {
    logic          vld;
    logic [TW-1:0] tag;
  } stage_t;

  logic [NUM_REQ-1:0] grant;
  logic [TW-1:0]      gidx;
  stage_t             stg [LATENCY];

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req_valid),
    .grant    (grant),
    .grant_idx(gidx)
  );

  assign req_ready = grant;

  always_comb begin
    pipe_a = '0;
    pipe_b = '0;
    if (|grant) begin
      pipe_a = req_a[int'(gidx)*WIDTH +: WIDTH];
      pipe_b = req_b[int'(gidx)*WIDTH +: WIDTH];
    end
  end

  // Tags track the adder's unreset data registers stage for stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LATENCY; k++) begin
        stg[k] <= '0;
      end
    end else begin
      stg[0] <= '{vld: |grant, tag: gidx};
      for (int k = 1; k < LATENCY; k++) begin
        stg[k] <= stg[k-1];
      end
    end
  end

  always_comb begin
    resp_valid = NUM_REQ'(stg[LATENCY-1].vld) << stg[LATENCY-1].tag;
  end

  assign resp_c = pipe_c;

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      busy = busy | stg[k].vld;
    end
  end

`ifdef ADD_ARB_PERF_EN
  cnt_t cnt [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) cnt[i] <= sat_inc(cnt[i]);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*16 +: 16] = cnt[i];
    end
  end
`endif

endmodule
